// File: rtl/player_motion_ctrl.sv
// Player square position controller: frame-rate movement from the decoded keycode,
// ESC pause toggle and a timed freeze after each respawn.
module player_motion_ctrl #(
    parameter int W         = 10,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 479,
    parameter int X_START   = 40,
    parameter int Y_START   = 240,
    parameter int STEP      = 2,
    parameter int FREEZE_FR = 30
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         frame_clk,
    input  logic [15:0]  keycode,
    input  logic         respawn,
    output logic [W-1:0] player_x,
    output logic [W-1:0] player_y,
    output logic         paused,
    output logic         frozen,
    output logic         moving
);
    // state  | meaning
    // PLAY   | player moves by STEP on each frame tick
    // PAUSED | position held until the next ESC press
    // FREEZE | position held for FREEZE_FR frame ticks after a respawn
    typedef enum logic [1:0] {PLAY, PAUSED, FREEZE} state_t;

    localparam int CW = $clog2(FREEZE_FR + 1);
    localparam logic [W:0]    X_MIN_E  = (W+1)'(X_MIN);
    localparam logic [W:0]    X_MAX_E  = (W+1)'(X_MAX);
    localparam logic [W:0]    Y_MIN_E  = (W+1)'(Y_MIN);
    localparam logic [W:0]    Y_MAX_E  = (W+1)'(Y_MAX);
    localparam logic [W:0]    STEP_E   = (W+1)'(STEP);
    localparam logic [W-1:0]  X_ST     = W'(X_START);
    localparam logic [W-1:0]  Y_ST     = W'(Y_START);
    localparam logic [CW-1:0] FRZ_LOAD = CW'(FREEZE_FR);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state_q, state_d;
    logic [W-1:0]  x_q, x_d, y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          moving_q, moving_d;
    logic          paused_q, frozen_q;
    logic          sync1_q, sync2_q, tick_prev_q, esc_prev_q;

    logic          frame_tick, esc_now, esc_edge;
    logic          go_l, go_r, go_u, go_d;
    logic [W:0]    x_e, y_e, x_mv, y_mv;
    logic [W-1:0]  x_new, y_new;
    logic          changed;

    assign frame_tick = sync2_q & ~tick_prev_q;
    assign esc_now    = (keycode == 16'h0029);
    assign esc_edge   = esc_now & ~esc_prev_q;

    always_comb begin
        go_l = 1'b0;
        go_r = 1'b0;
        go_u = 1'b0;
        go_d = 1'b0;
        case (keycode)
            16'h0004: go_l = 1'b1;
            16'h0007: go_r = 1'b1;
            16'h0016: go_d = 1'b1;
            16'h001A: go_u = 1'b1;
            16'h1A04: begin go_u = 1'b1; go_l = 1'b1; end
            16'h0416: begin go_d = 1'b1; go_l = 1'b1; end
            16'h1607: begin go_d = 1'b1; go_r = 1'b1; end
            16'h071A: begin go_u = 1'b1; go_r = 1'b1; end
            default: ;
        endcase
    end

    // One spare bit so the +STEP sum cannot wrap before the clamp compare.
    always_comb begin
        x_e = {1'b0, x_q};
        y_e = {1'b0, y_q};
        if (go_l)      x_mv = (x_e < X_MIN_E + STEP_E) ? X_MIN_E : x_e - STEP_E;
        else if (go_r) x_mv = (x_e + STEP_E > X_MAX_E) ? X_MAX_E : x_e + STEP_E;
        else           x_mv = x_e;
        if (go_u)      y_mv = (y_e < Y_MIN_E + STEP_E) ? Y_MIN_E : y_e - STEP_E;
        else if (go_d) y_mv = (y_e + STEP_E > Y_MAX_E) ? Y_MAX_E : y_e + STEP_E;
        else           y_mv = y_e;
        x_new   = x_mv[W-1:0];
        y_new   = y_mv[W-1:0];
        changed = (x_new != x_q) || (y_new != y_q);
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        moving_d = moving_q;
        case (state_q)
            PLAY: begin
                if (respawn) begin
                    x_d      = X_ST;
                    y_d      = Y_ST;
                    cnt_d    = FRZ_LOAD;
                    moving_d = 1'b0;
                    state_d  = FREEZE;
                end else if (esc_edge) begin
                    state_d = PAUSED;
                    if (frame_tick) moving_d = 1'b0;
                end else if (frame_tick) begin
                    x_d      = x_new;
                    y_d      = y_new;
                    moving_d = changed;
                end
            end
            PAUSED: begin
                moving_d = 1'b0;
                if (esc_edge) state_d = PLAY;
            end
            FREEZE: begin
                moving_d = 1'b0;
                if (respawn) begin
                    cnt_d = FRZ_LOAD;
                end else if (frame_tick) begin
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = PLAY;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= PLAY;
            x_q         <= X_ST;
            y_q         <= Y_ST;
            cnt_q       <= '0;
            moving_q    <= 1'b0;
            paused_q    <= 1'b0;
            frozen_q    <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            tick_prev_q <= 1'b0;
            esc_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            moving_q    <= moving_d;
            paused_q    <= (state_q == PAUSED);
            frozen_q    <= (state_q == FREEZE);
            sync1_q     <= frame_clk;
            sync2_q     <= sync1_q;
            tick_prev_q <= sync2_q;
            esc_prev_q  <= esc_now;
        end
    end

    assign player_x = x_q;
    assign player_y = y_q;
    assign paused   = paused_q;
    assign frozen   = frozen_q;
    assign moving   = moving_q;
endmodule
